branch_redirect_ctrl: RTL

Sequences every control-flow redirect in the pipeline. Three sources compete for the fetch PC: the EX-stage taken/not-taken result for branches and jumps, CSR trap entry, and mret return. The block arbitrates between them, holds the winning redirect until fetch accepts it, and drives the IF/ID and ID/EX flushes. It also flags misaligned branch targets to the CSR unit and keeps redirect statistics counters.

---
 rtl/branch_redirect_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: arbitrates trap/mret/branch redirects, holds the winner until fetch accepts it
//
// Ports:
//    clk, rst                     clock, synchronous active-high reset
//    ex_valid, ex_br_taken        EX-stage valid instruction and taken result
//    ex_target                    EX-stage branch/jump target
//    stall_in                     pipeline frozen (blocks branch events only)
//    trap_req, trap_vec           CSR trap entry request and handler address
//    mret_req, mret_epc           CSR trap return request and return address
//    redir_valid, redir_pc        redirect offered to fetch
//    redir_ready                  fetch accepts the redirect this cycle
//    flush_ifid, flush_idex       kill IF/ID and ID/EX contents
//    hold_fetch                   fetch must not advance sequentially
//    misalign_o, misalign_addr    one-cycle pulse and address for a misaligned taken target
//    br_cnt, trap_cnt             accepted branch and trap/mret redirect counters
module branch_redirect_ctrl #(
   parameter int REG_SIZE = 32,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ex_valid,
   input  logic                ex_br_taken,
   input  logic [REG_SIZE-1:0] ex_target,
   input  logic                stall_in,
   input  logic                trap_req,
   input  logic [REG_SIZE-1:0] trap_vec,
   input  logic                mret_req,
   input  logic [REG_SIZE-1:0] mret_epc,
   output logic                redir_valid,
   output logic [REG_SIZE-1:0] redir_pc,
   input  logic                redir_ready,
   output logic                flush_ifid,
   output logic                flush_idex,
   output logic                hold_fetch,
   output logic                misalign_o,
   output logic [REG_SIZE-1:0] misalign_addr,
   output logic [CNT_W-1:0]    br_cnt,
   output logic [CNT_W-1:0]    trap_cnt
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PEND = 1'b1;
   localparam logic [1:0] SRC_BR   = 2'd0;
   localparam logic [1:0] SRC_MRET = 2'd1;
   localparam logic [1:0] SRC_TRAP = 2'd2;

   logic [0:0]          state_q, state_d;
   logic [1:0]          src_q, src_d;
   logic [REG_SIZE-1:0] pc_q, pc_d;
   logic                tpend_q, tpend_d;
   logic [REG_SIZE-1:0] tvec_q, tvec_d;
   logic                mis_q;
   logic [REG_SIZE-1:0] maddr_q;
   logic [CNT_W-1:0]    br_cnt_q, trap_cnt_q;
   logic                idle, t_ev, m_ev, b_ev, b_mis, b_ok, capture, accept;
   logic [REG_SIZE-1:0] t_pc;

   // A trap that arrived while an older redirect was being accepted is remembered
   // here so it is captured in the following IDLE cycle even if trap_req was a pulse.
   assign idle    = state_q == IDLE;
   assign t_ev    = trap_req | tpend_q;
   assign t_pc    = trap_req ? trap_vec : tvec_q;
   assign m_ev    = mret_req & !t_ev;
   assign b_ev    = ex_valid & ex_br_taken & !stall_in & !t_ev & !m_ev;
   assign b_mis   = b_ev & (ex_target[1:0] != 2'b00);
   assign b_ok    = b_ev & !b_mis;
   assign capture = idle & (t_ev | m_ev | b_ok);
   assign accept  = !idle & redir_ready;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      pc_d    = pc_q;
      tpend_d = 1'b0;
      tvec_d  = trap_vec;
      if (idle) begin
         if (capture) begin
            state_d = PEND;
            src_d   = t_ev ? SRC_TRAP : m_ev ? SRC_MRET : SRC_BR;
            pc_d    = t_ev ? t_pc : m_ev ? mret_epc : ex_target;
         end
      end else if (accept) begin
         state_d = IDLE;
         tpend_d = trap_req & (src_q != SRC_TRAP);
      end else if (trap_req && src_q != SRC_TRAP) begin
         src_d = SRC_TRAP;
         pc_d  = trap_vec;
      end else if (m_ev && src_q == SRC_BR) begin
         src_d = SRC_MRET;
         pc_d  = mret_epc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         src_q      <= SRC_BR;
         pc_q       <= '0;
         tpend_q    <= 1'b0;
         tvec_q     <= '0;
         mis_q      <= 1'b0;
         maddr_q    <= '0;
         br_cnt_q   <= '0;
         trap_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         pc_q       <= pc_d;
         tpend_q    <= tpend_d;
         tvec_q     <= tvec_d;
         mis_q      <= idle & b_mis;
         maddr_q    <= (idle & b_mis) ? ex_target : maddr_q;
         br_cnt_q   <= (accept && src_q == SRC_BR) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
         trap_cnt_q <= (accept && src_q != SRC_BR) ? trap_cnt_q + CNT_W'(1) : trap_cnt_q;
      end
   end

   assign redir_valid   = !idle;
   assign redir_pc      = pc_q;
   assign hold_fetch    = !idle;
   assign flush_ifid    = !idle | capture;
   assign flush_idex    = !idle | capture;
   assign misalign_o    = mis_q;
   assign misalign_addr = maddr_q;
   assign br_cnt        = br_cnt_q;
   assign trap_cnt      = trap_cnt_q;
endmodule
